// File: rtl/wf_rr_grant_arbiter.sv
// Round-robin grant arbiter for SIZE wavefront slots; the grant is held until acked or withdrawn.
// Optional macro ARB_TIMEOUT_EN adds a grant-hold watchdog that force-releases after TIMEOUT cycles.
module wf_rr_grant_arbiter #(
    parameter int BITS    = 6,
    parameter int SIZE    = 40,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SIZE-1:0]   request,
    input  logic              grant_ack,
    output logic              grant_valid,
    output logic [BITS-1:0]   grant_id,
    output logic [SIZE-1:0]   grant_onehot,
    output logic              timeout_pulse
);
    localparam int PADW = 1 << BITS;

    if (SIZE < 2 || SIZE > PADW || TIMEOUT < 1) begin : g_bad_cfg
        $error("wf_rr_grant_arbiter: illegal BITS/SIZE/TIMEOUT combination");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic [BITS-1:0] last_id;
    logic [BITS:0]   idle_hit;
    logic [BITS:0]   next_hit;
    logic            held;
    logic            timeout_hit;

    // Scan from+1 upward, wrapping at SIZE; returns {found, index}. 'from' itself is checked last.
    function automatic logic [BITS:0] rr_search(input logic [BITS-1:0] from,
                                                input logic [SIZE-1:0] req);
        logic [PADW-1:0] pad;
        logic [BITS:0]   sum;
        logic [BITS:0]   res;
        pad            = '0;
        pad[SIZE-1:0]  = req;
        res            = '0;
        for (int k = 1; k <= SIZE; k++) begin
            sum = {1'b0, from} + (BITS+1)'(k);
            if (sum >= (BITS+1)'(SIZE))
                sum = sum - (BITS+1)'(SIZE);
            if (!res[BITS] && pad[sum[BITS-1:0]])
                res = {1'b1, sum[BITS-1:0]};
        end
        return res;
    endfunction

    function automatic logic [SIZE-1:0] to_onehot(input logic [BITS-1:0] idx);
        logic [PADW-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v[SIZE-1:0];
    endfunction

    // In HOLD grant_onehot marks the held slot, so it doubles as the exclusion mask.
    always_comb begin
        idle_hit = rr_search(last_id, request);
        next_hit = rr_search(grant_id, request & ~grant_onehot);
        held     = |(request & grant_onehot);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] hold_cnt;

    always_comb timeout_hit = (state == HOLD) && (hold_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst)
            hold_cnt <= '0;
        else if (state != HOLD || grant_ack || timeout_hit || !held)
            hold_cnt <= '0;
        else
            hold_cnt <= hold_cnt + 1'b1;
    end
`else
    always_comb timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant_valid   <= 1'b0;
            grant_id      <= '0;
            grant_onehot  <= '0;
            timeout_pulse <= 1'b0;
            last_id       <= BITS'(SIZE - 1);
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (idle_hit[BITS]) begin
                        state        <= HOLD;
                        grant_valid  <= 1'b1;
                        grant_id     <= idle_hit[BITS-1:0];
                        grant_onehot <= to_onehot(idle_hit[BITS-1:0]);
                    end
                end
                HOLD: begin
                    // Ack wins over a simultaneous withdrawal; a watchdog release behaves as an ack.
                    if (grant_ack || timeout_hit) begin
                        last_id       <= grant_id;
                        timeout_pulse <= ~grant_ack;
                        if (next_hit[BITS]) begin
                            grant_id     <= next_hit[BITS-1:0];
                            grant_onehot <= to_onehot(next_hit[BITS-1:0]);
                        end else begin
                            state        <= IDLE;
                            grant_valid  <= 1'b0;
                            grant_id     <= '0;
                            grant_onehot <= '0;
                        end
                    end else if (!held) begin
                        state        <= IDLE;
                        grant_valid  <= 1'b0;
                        grant_id     <= '0;
                        grant_onehot <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/wf_rr_grant_arbiter.md
Name: wf_rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (e.g. the issue port) among SIZE wavefront-slot requesters.
- Holds each grant until the consumer acknowledges it.
- Presents the winner both as a binary index and as an enable-gated one-hot vector.
- Sits between per-slot ready logic and the single-consumer stage that takes one slot at a time.

Parameters:
- BITS, 6, width of the grant index; SIZE <= 2**BITS is required.
- SIZE, 40, number of requesters; SIZE >= 2.
- TIMEOUT, 255, grant-hold watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  Rising-edge clock.
- rst  input  1  Reset; synchronous, active-high. This is already decided.
- request  input  SIZE  Per-slot request; bit i high means slot i wants the resource.
- grant_ack  input  1  Consumer accepts the current grant this cycle.
- grant_valid  output  1  A grant is being held.
- grant_id  output  BITS  Index of the granted slot.
- grant_onehot  output  SIZE  Bit grant_id set when grant_valid is high; all zero otherwise.
- timeout_pulse  output  1  One-cycle flag for a watchdog release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- All outputs are registered.
- Reset, applied at a clock edge while rst=1:
  - grant_valid=0, grant_id=0, grant_onehot=0, timeout_pulse=0.
  - State IDLE.
  - Internal pointer last_id=SIZE-1, so the first search starts at slot 0.
  - Watchdog counter=0.
- rst overrides everything, including a grant currently held.
- Search function:
  - Starting at last_id+1, scan upward and wrap from SIZE-1 to 0. Pick the first index with request=1.
  - last_id itself is checked last.
  - Wrap is computed against SIZE, not 2**BITS.
- State IDLE:
  - If any request bit is high, load grant_id=search result, set grant_valid=1 and grant_onehot, go to HOLD.
  - Latency is one cycle: request seen at edge N gives grant_valid=1 after edge N.
  - If no request bit is high, stay in IDLE with outputs 0.
- State HOLD:
  - The grant is stable. grant_id and grant_onehot must not change while grant_valid=1 and there is neither an ack nor a withdrawal.
- Ack in HOLD (grant_ack=1):
  - last_id <= grant_id.
  - A new search is computed in the same cycle using the updated rotation (start at grant_id+1) and the current request vector, excluding bit grant_id.
  - If a winner exists, grant_id is reloaded and the state stays HOLD. This gives back-to-back grants with no bubble.
  - Otherwise grant_valid=0 and the state goes to IDLE.
  - The acked slot becomes eligible again only from the next search onward.
- Withdrawal: request[grant_id] drops while in HOLD with no ack.
  - The grant is cancelled: grant_valid=0, go to IDLE.
  - last_id is unchanged.
- Ack and withdrawal in the same cycle: treated as an ack.
- grant_ack while in IDLE is ignored.
- request bits at indices >= SIZE do not exist; no out-of-range grant_id is ever produced.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter of width clog2(TIMEOUT+1) counts the cycles spent in HOLD on the same grant. It clears on every new grant, ack or withdrawal.
  - When the counter equals TIMEOUT with no ack, the grant is force-released exactly as if acked: last_id advances, and the next search or IDLE transition follows the ack rules.
  - timeout_pulse=1 for that one cycle.
- Without the macro: no counter exists, timeout_pulse is constant 0, and a grant is held indefinitely.

Test Plan (SIZE=4, BITS=2, TIMEOUT=3 where relevant):
- Reset, then request=4'b0000 for 5 cycles -> grant_valid=0 and grant_onehot=0 throughout.
- Requests held, ack every cycle:
  - request=4'b1111 held, grant_ack=1 every cycle -> grant_id sequence 0,1,2,3,0 with grant_valid continuously 1.
  - grant_onehot sequence 0001,0010,0100,1000.
- Hold without ack: request=4'b0100 for 4 cycles, no ack -> grant_id=2 and grant_valid=1 stable. Then ack -> grant_valid=0 the next cycle.
- Rotation after an ack:
  - Grant slot 3, ack, then request=4'b1001 -> next grant_id=0 (the wrap is exercised).
  - Then ack with request=4'b1001 -> grant_id=3.
- Withdrawal and reset while held:
  - Grant slot 1, then drop request[1] without ack -> grant_valid=0. The next request=4'b0011 grants slot 0, because the pointer did not advance.
  - Assert rst mid-HOLD -> all outputs 0 the next cycle.
- With ARB_TIMEOUT_EN: request=4'b0010, no ack -> timeout_pulse=1 on the cycle the counter reaches 3 while in HOLD. After that cycle grant_valid=0. Without the macro, grant_valid stays 1 for 20 cycles.
